// File: rtl/ucode_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ucode_sequencer
// Brief    : Microcode control unit. Owns the T-state counter, forms the
//            microcode ROM address {opcode, tstate}, and decodes the returned
//            microinstruction into one-hot bus enables, ALU control, RT/P+
//            strobes and a flag-resolved jump load. Adds a post-reset idle
//            cycle and a stall handshake.
// Ports    : clk        - system clock, rising edge
//            reset      - asynchronous, active-high
//            opcode     - current IR opcode
//            uaddr      - microcode ROM address {opcode, tstate}
//            uinstr     - ROM data for uaddr (combinational, same cycle)
//            stall      - datapath not ready; freezes sequencing
//            flag_c/z/n - ALU carry / zero / negative
//            eo         - ALU drives the bus
//            alu_flags  - raw ALU control field
//            out_en     - one-hot bus source enable
//            in_en      - one-hot bus sink enable (code 0 = no sink)
//            rt         - end of instruction, T-state returns to 0
//            pa         - PC increment
//            jmp        - load PC from bus (jump taken)
//            tstate     - current T-state (debug)
// Revision : 1.0 - initial release
// ============================================================================
module ucode_sequencer #(
    parameter int SEL_W = 3,   // select field width, legal 2..4
    parameter int TS_W  = 3,   // T-state counter width
    parameter int OP_W  = 8,   // opcode width
    parameter int UW    = 16   // microinstruction width
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [OP_W-1:0]         opcode,
    output logic [OP_W+TS_W-1:0]    uaddr,
    input  logic [UW-1:0]           uinstr,
    input  logic                    stall,
    input  logic                    flag_c,
    input  logic                    flag_z,
    input  logic                    flag_n,
    output logic                    eo,
    output logic [SEL_W+2:0]        alu_flags,
    output logic [(2**SEL_W)-1:0]   out_en,
    output logic [(2**SEL_W)-1:0]   in_en,
    output logic                    rt,
    output logic                    pa,
    output logic                    jmp,
    output logic [TS_W-1:0]         tstate
);

    // ------------------------------------------------------------------
    // Microinstruction field positions, MSB to LSB:
    //   EO | ALU[SEL_W+3] | in_sel[SEL_W] | JC JZ JGT JLT | spare
    // With EO=0 the ALU field is reinterpreted as {out_sel, RT, P+, -}.
    // ------------------------------------------------------------------
    localparam int c_ALU_W    = SEL_W + 3;
    localparam int c_NSEL     = 2 ** SEL_W;
    localparam int c_EO_BIT   = UW - 1;
    localparam int c_ALU_LSB  = c_EO_BIT - c_ALU_W;
    localparam int c_OSEL_LSB = c_ALU_LSB + 3;
    localparam int c_RT_BIT   = c_ALU_LSB + 2;
    localparam int c_PA_BIT   = c_ALU_LSB + 1;
    localparam int c_ISEL_LSB = c_ALU_LSB - SEL_W;
    localparam int c_JC_BIT   = c_ISEL_LSB - 1;
    localparam int c_JZ_BIT   = c_ISEL_LSB - 2;
    localparam int c_JGT_BIT  = c_ISEL_LSB - 3;
    localparam int c_JLT_BIT  = c_ISEL_LSB - 4;
    localparam int c_SPARE    = c_JLT_BIT;   // number of unused low bits

    localparam logic [c_NSEL-1:0] c_ONE = {{(c_NSEL-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              r_state_q;
    state_t              w_state_d;
    logic [TS_W-1:0]     r_tstate_q;
    logic [TS_W-1:0]     w_tstate_d;

    // Raw field extraction
    logic                w_eo_bit;
    logic [SEL_W-1:0]    w_out_sel;
    logic [SEL_W-1:0]    w_in_sel;
    logic                w_rt_bit;
    logic                w_pa_bit;
    logic                w_jc;
    logic                w_jz;
    logic                w_jgt;
    logic                w_jlt;
    logic                w_jump_cond;
    logic                w_run;

    assign w_eo_bit  = uinstr[c_EO_BIT];
    assign w_out_sel = uinstr[c_OSEL_LSB +: SEL_W];
    assign w_in_sel  = uinstr[c_ISEL_LSB +: SEL_W];
    assign w_rt_bit  = uinstr[c_RT_BIT];
    assign w_pa_bit  = uinstr[c_PA_BIT];
    assign w_jc      = uinstr[c_JC_BIT];
    assign w_jz      = uinstr[c_JZ_BIT];
    assign w_jgt     = uinstr[c_JGT_BIT];
    assign w_jlt     = uinstr[c_JLT_BIT];

    // JGT means strictly positive: neither zero nor negative.
    assign w_jump_cond = (w_jc  & flag_c)
                       | (w_jz  & flag_z)
                       | (w_jgt & ~flag_z & ~flag_n)
                       | (w_jlt & flag_n);

    assign w_run = (r_state_q == ST_RUN);

    // Spare low bits carry no meaning; collect them so they are visibly
    // consumed rather than silently dangling.
    generate
        if (c_SPARE > 0) begin : g_spare
            logic w_unused_spare;
            assign w_unused_spare = ^uinstr[c_SPARE-1:0];
        end else begin : g_no_spare
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output decode. Every enable is qualified by the RUN state, which is
    // itself cleared asynchronously, so asserting reset kills all enables
    // in the same cycle without waiting for a clock edge.
    // ------------------------------------------------------------------
    always_comb begin
        eo        = 1'b0;
        out_en    = '0;
        in_en     = '0;
        rt        = 1'b0;
        pa        = 1'b0;
        jmp       = 1'b0;
        alu_flags = uinstr[c_EO_BIT-1 -: c_ALU_W];

        if (w_run) begin
            eo = w_eo_bit;
            if (!w_eo_bit) begin
                out_en = c_ONE << w_out_sel;
                rt     = w_rt_bit;
                // PC strobes are suppressed while stalled so the held
                // microinstruction does not increment or load PC twice.
                pa     = w_pa_bit & ~stall;
            end
            if (w_in_sel != '0) begin
                in_en = c_ONE << w_in_sel;
            end
            jmp = w_jump_cond & ~stall;
        end
    end

    // ------------------------------------------------------------------
    // Sequencing. IDLE always lasts one clock and is left unconditionally;
    // in RUN, stall has priority, then RT, then the natural increment
    // (which wraps at NT-1 through counter overflow).
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d  = r_state_q;
        w_tstate_d = r_tstate_q;
        case (r_state_q)
            ST_IDLE: begin
                w_state_d  = ST_RUN;
                w_tstate_d = '0;
            end
            ST_RUN: begin
                if (stall) begin
                    w_tstate_d = r_tstate_q;
                end else if (rt) begin
                    w_tstate_d = '0;
                end else begin
                    w_tstate_d = r_tstate_q + 1'b1;
                end
            end
            default: begin
                w_state_d  = ST_IDLE;
                w_tstate_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q  <= ST_IDLE;
            r_tstate_q <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_tstate_q <= w_tstate_d;
        end
    end

    assign uaddr  = {opcode, r_tstate_q};
    assign tstate = r_tstate_q;

endmodule
`default_nettype wire

// File: tb/tb_ucode_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ucode_sequencer
// Brief    : Self-checking bench for ucode_sequencer. Directed scenarios plus
//            randomized cycles compared against a field-level behavioural
//            model; a second instance exercises the 4-bit select width.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ucode_sequencer;

    localparam int SEL_W   = 3;
    localparam int TS_W    = 3;
    localparam int OP_W    = 8;
    localparam int UW      = 16;
    localparam int NT      = 2 ** TS_W;
    localparam int ALU_W   = SEL_W + 3;
    localparam int ALU_LSB = UW - 1 - ALU_W;   // 9
    localparam int IN_LSB  = ALU_LSB - SEL_W;  // 6

    logic                   clk;
    logic                   reset;
    logic [OP_W-1:0]        opcode;
    logic [OP_W+TS_W-1:0]   uaddr;
    logic [UW-1:0]          uinstr;
    logic                   stall;
    logic                   flag_c, flag_z, flag_n;
    logic                   eo;
    logic [SEL_W+2:0]       alu_flags;
    logic [(2**SEL_W)-1:0]  out_en;
    logic [(2**SEL_W)-1:0]  in_en;
    logic                   rt, pa, jmp;
    logic [TS_W-1:0]        tstate;

    // Second instance, SEL_W=4 (UW = 1+7+4+4 = 16, no spare)
    logic [OP_W-1:0]        opcode2;
    logic [OP_W+TS_W-1:0]   uaddr2;
    logic [UW-1:0]          uinstr2;
    logic                   eo2;
    logic [6:0]             alu_flags2;
    logic [15:0]            out_en2;
    logic [15:0]            in_en2;
    logic                   rt2, pa2, jmp2;
    logic [TS_W-1:0]        tstate2;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit m_run = 0;
    int m_t   = 0;

    ucode_sequencer #(.SEL_W(SEL_W), .TS_W(TS_W), .OP_W(OP_W), .UW(UW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .uaddr(uaddr),
        .uinstr(uinstr), .stall(stall),
        .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n),
        .eo(eo), .alu_flags(alu_flags), .out_en(out_en), .in_en(in_en),
        .rt(rt), .pa(pa), .jmp(jmp), .tstate(tstate)
    );

    ucode_sequencer #(.SEL_W(4), .TS_W(TS_W), .OP_W(OP_W), .UW(UW)) dut4 (
        .clk(clk), .reset(reset), .opcode(opcode2), .uaddr(uaddr2),
        .uinstr(uinstr2), .stall(1'b0),
        .flag_c(1'b0), .flag_z(1'b0), .flag_n(1'b0),
        .eo(eo2), .alu_flags(alu_flags2), .out_en(out_en2), .in_en(in_en2),
        .rt(rt2), .pa(pa2), .jmp(jmp2), .tstate(tstate2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int fld(input int u, input int lsb, input int w);
        return (u >> lsb) & ((1 << w) - 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs derived from the field rules for the current inputs
    task automatic check_model();
        int u, eo_e, osel, isel, rt_e, pa_e, jt, jmp_e;
        logic [31:0] e_out, e_in;
        u     = int'(uinstr);
        eo_e  = m_run ? fld(u, UW-1, 1) : 0;
        osel  = fld(u, ALU_LSB+3, SEL_W);
        isel  = fld(u, IN_LSB, SEL_W);
        rt_e  = (m_run && eo_e == 0) ? fld(u, ALU_LSB+2, 1) : 0;
        pa_e  = (m_run && eo_e == 0 && !stall) ? fld(u, ALU_LSB+1, 1) : 0;
        jt    = ((fld(u, IN_LSB-1, 1) == 1) && flag_c)
             || ((fld(u, IN_LSB-2, 1) == 1) && flag_z)
             || ((fld(u, IN_LSB-3, 1) == 1) && !flag_z && !flag_n)
             || ((fld(u, IN_LSB-4, 1) == 1) && flag_n) ? 1 : 0;
        jmp_e = (m_run && !stall) ? jt : 0;
        e_out = (m_run && eo_e == 0) ? (32'd1 << osel) : 32'd0;
        e_in  = (m_run && isel != 0) ? (32'd1 << isel) : 32'd0;
        chk("uaddr",     32'(uaddr),     32'(int'(opcode) * NT + m_t));
        chk("tstate",    32'(tstate),    32'(m_t));
        chk("alu_flags", 32'(alu_flags), 32'(fld(u, ALU_LSB, ALU_W)));
        chk("eo",        32'(eo),        32'(eo_e));
        chk("out_en",    32'(out_en),    e_out);
        chk("in_en",     32'(in_en),     e_in);
        chk("rt",        32'(rt),        32'(rt_e));
        chk("pa",        32'(pa),        32'(pa_e));
        chk("jmp",       32'(jmp),       32'(jmp_e));
    endtask

    task automatic sample_check();
        @(negedge clk);
        check_model();
    endtask

    // Advance one clock and update the model with the same rules
    task automatic advance();
        int u;
        bit rt_e;
        @(posedge clk);
        u    = int'(uinstr);
        rt_e = m_run && fld(u, UW-1, 1) == 0 && fld(u, ALU_LSB+2, 1) == 1;
        if (reset) begin
            m_run = 0; m_t = 0;
        end else if (!m_run) begin
            m_run = 1; m_t = 0;
        end else if (stall) begin
            m_t = m_t;
        end else if (rt_e) begin
            m_t = 0;
        end else begin
            m_t = (m_t + 1) % NT;
        end
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        opcode  = '0;
        uinstr  = '0;
        stall   = 1'b0;
        flag_c  = 1'b0;
        flag_z  = 1'b0;
        flag_n  = 1'b0;
        opcode2 = 8'h21;
        uinstr2 = 16'h48C0;   // out_sel=9, in_sel=12

        // ---- Reset, then release: one IDLE cycle, then RUN at T0 ----
        @(posedge clk); #1;
        check_model();
        chk("rst_in_en", 32'(in_en), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        sample_check();
        chk("idle_uaddr",  32'(uaddr),  32'h000);
        chk("idle_out_en", 32'(out_en), 32'h0);
        chk("idle_in_en",  32'(in_en),  32'h0);
        advance();

        // ---- opcode 0x12, X -> MAR, T-states 0..7,0 ----
        opcode = 8'h12;
        uinstr = 16'h4040;
        for (int i = 0; i < NT + 1; i++) begin
            sample_check();
            chk("seq_uaddr",  32'(uaddr),  32'h090 + 32'(i % NT));
            chk("seq_out_en", 32'(out_en), 32'h10);
            chk("seq_in_en",  32'(in_en),  32'h02);
            advance();
        end

        // ---- ALU drives bus ----
        uinstr = 16'hFF40;
        sample_check();
        chk("alu_eo",     32'(eo),        32'h1);
        chk("alu_flags",  32'(alu_flags), 32'h3F);
        chk("alu_out_en", 32'(out_en),    32'h0);
        chk("alu_rt",     32'(rt),        32'h0);
        chk("alu_in_en",  32'(in_en),     32'h20);
        advance();

        // ---- Walk to T2, then RT with stall ----
        uinstr = 16'h0000;
        for (int k = 0; k < 2 * NT && m_t != 2; k++) begin
            sample_check();
            advance();
        end
        chk("reach_t2", 32'(tstate), 32'h2);
        uinstr = 16'h0C00;   // RT + P+
        stall  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sample_check();
            chk("stall_t",  32'(tstate), 32'h2);
            chk("stall_pa", 32'(pa),     32'h0);
            advance();
        end
        stall = 1'b0;
        sample_check();
        chk("rt_pa", 32'(pa), 32'h1);
        advance();
        chk("rt_t0", 32'(tstate), 32'h0);

        // ---- Jumps ----
        uinstr = 16'h0010; flag_z = 1'b1;
        sample_check(); chk("jz", 32'(jmp), 32'h1); advance();
        uinstr = 16'h0008; flag_z = 1'b0; flag_n = 1'b0;
        sample_check(); chk("jgt_pos", 32'(jmp), 32'h1); advance();
        flag_n = 1'b1;
        sample_check(); chk("jgt_neg", 32'(jmp), 32'h0); advance();
        uinstr = 16'h0004; stall = 1'b1;
        sample_check(); chk("jlt_stall", 32'(jmp), 32'h0); advance();
        stall = 1'b0; flag_n = 1'b0;

        // ---- Async reset mid-instruction at T5 with in_en=0x08 ----
        uinstr = 16'h00C0;
        for (int k = 0; k < 2 * NT && m_t != 5; k++) begin
            sample_check();
            advance();
        end
        chk("mid_t5",    32'(tstate), 32'h5);
        chk("mid_in_en", 32'(in_en),  32'h08);
        #2;
        reset = 1'b1;
        m_run = 0; m_t = 0;
        #1;
        chk("async_in_en",  32'(in_en),  32'h0);
        chk("async_out_en", 32'(out_en), 32'h0);
        chk("async_tstate", 32'(tstate), 32'h0);
        advance();
        reset = 1'b0;
        sample_check();
        chk("post_idle_in_en", 32'(in_en), 32'h0);
        advance();
        sample_check();
        chk("post_run_in_en", 32'(in_en), 32'h08);

        // ---- SEL_W=4 instance ----
        chk("sel4_out_en", 32'(out_en2), 32'h0200);
        chk("sel4_in_en",  32'(in_en2),  32'h1000);
        advance();

        // ---- Randomized cycles ----
        for (int i = 0; i < 400; i++) begin
            opcode = 8'($urandom);
            uinstr = 16'($urandom);
            flag_c = 1'($urandom);
            flag_z = 1'($urandom);
            flag_n = 1'($urandom);
            stall  = ($urandom_range(0, 3) == 0);
            if (!reset && $urandom_range(0, 49) == 0) begin
                reset = 1'b1;
                m_run = 0; m_t = 0;
            end else begin
                reset = 1'b0;
            end
            sample_check();
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
